// File: rtl/sram_burst_ctrl.sv
// sram_burst_ctrl: burst command controller for an asynchronous SRAM with programmable access wait states.
module sram_burst_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 3,
    parameter int WAIT_CYC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              req_ready,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_ce,
    output logic              sram_oe,
    output logic              sram_we
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    state_t state, state_nx;
    logic rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0] beat_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0] wait_q;
    logic last_acc;
    assign last_acc = state == ACCESS && wait_q == 4'(WAIT_CYC);
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   state_nx = req ? SETUP : IDLE;
            SETUP:  state_nx = (rw_q || wr_valid) ? ACCESS : SETUP;
            ACCESS: state_nx = !last_acc ? ACCESS : (beat_q == '0 ? DONE : SETUP);
            DONE:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            beat_q   <= '0;
            wdata_q  <= '0;
            wait_q   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nx;
            rd_valid <= last_acc && rw_q;
            wait_q   <= (state == ACCESS && !last_acc) ? wait_q + 4'd1 : 4'd0;
            if (last_acc && rw_q)
                rd_data <= sram_data;
            if (state == IDLE && req) begin
                rw_q   <= rw;
                addr_q <= addr;
                beat_q <= len;
            end
            if (state == SETUP && !rw_q && wr_valid)
                wdata_q <= wr_data;
            // address only moves on the edge into the next SETUP, so it is stable for a whole beat
            if (last_acc && beat_q != '0) begin
                beat_q <= beat_q - 1'b1;
                addr_q <= addr_q + 1'b1;
            end
        end
    end
    assign req_ready = state == IDLE;
    assign wr_ready  = state == SETUP && !rw_q;
    assign done      = state == DONE;
    assign sram_addr = addr_q;
    assign sram_ce   = !(state == SETUP || state == ACCESS);
    assign sram_oe   = !(state == ACCESS && rw_q);
    assign sram_we   = !(state == ACCESS && !rw_q);
    assign sram_data = (state == ACCESS && !rw_q) ? wdata_q : 'z;
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// tb_sram_burst_ctrl: randomized bench for two controllers (WAIT_CYC 0 and 3) against a cycle-timeline reference model.
module tb_sram_burst_ctrl;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int LW = 3;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    logic req [2], rw [2], wr_valid [2];
    logic [AW-1:0] addr [2];
    logic [LW-1:0] len [2];
    logic [DW-1:0] wr_data [2];
    logic req_ready [2], wr_ready [2], rd_valid [2], done [2], ce [2], oe [2], we [2];
    logic [DW-1:0] rd_data [2];
    logic [AW-1:0] sa [2];
    wire [DW-1:0] sd_obs [2];
    logic [DW-1:0] ref_mem [2][256];
    int vec = 0;
    int errs = 0;
    function automatic logic [DW-1:0] init_val(int i);
        return DW'(16'h0FE0 + i);
    endfunction
    for (genvar g = 0; g < 2; g++) begin : inst
        wire [DW-1:0] bus;
        logic [DW-1:0] mem [256];
        sram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .WAIT_CYC(3 * g)) dut (
            .clk(clk), .reset(reset), .req(req[g]), .req_ready(req_ready[g]), .rw(rw[g]),
            .addr(addr[g]), .len(len[g]), .wr_data(wr_data[g]), .wr_valid(wr_valid[g]),
            .wr_ready(wr_ready[g]), .rd_data(rd_data[g]), .rd_valid(rd_valid[g]), .done(done[g]),
            .sram_addr(sa[g]), .sram_data(bus), .sram_ce(ce[g]), .sram_oe(oe[g]), .sram_we(we[g])
        );
        assign bus = (!ce[g] && !oe[g]) ? mem[sa[g]] : 'z;
        assign sd_obs[g] = bus;
        initial begin
            for (int i = 0; i < 256; i++) mem[i] = init_val(i);
            forever begin
                @(posedge clk);
                if (!ce[g] && !we[g]) mem[sa[g]] = bus;
            end
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n, input int c);
        for (int i = 0; i < c; i++) begin
            @(negedge clk);
            check("idle_strobes", {ce[n], oe[n], we[n]}, 3'b111);
            check("idle_req_ready", req_ready[n], 1'b1);
            check("idle_pulses", {done[n], rd_valid[n], wr_ready[n]}, 3'b000);
            step();
        end
    endtask
    // Expected behaviour is a timeline: per beat one SETUP (plus write stalls), WAIT+1 ACCESS cycles, then DONE.
    task automatic run_cmd(input int n, input bit r, input logic [AW-1:0] a, input int l,
                           input int gmax, input int g2, input int wfix, input bit busy, input int abort_k);
        int w = 3 * n;
        int gap;
        logic [AW-1:0] ea;
        logic [DW-1:0] wd;
        wd = '0;
        req[n] = 1'b1; rw[n] = r; addr[n] = a; len[n] = LW'(l);
        @(negedge clk);
        check("accept_req_ready", req_ready[n], 1'b1);
        check("accept_strobes", {ce[n], oe[n], we[n]}, 3'b111);
        step();
        req[n] = busy; rw[n] = ~r; addr[n] = a ^ 8'h55; len[n] = LW'($urandom);
        for (int k = 0; k <= l; k++) begin
            ea = 8'(a + k);
            if (!r) begin
                gap = (k == 2 && g2 >= 0) ? g2 : int'($urandom_range(gmax, 0));
                wd = (wfix >= 0) ? DW'(wfix) : DW'($urandom);
                for (int i = 0; i <= gap; i++) begin
                    wr_valid[n] = (i == gap);
                    wr_data[n] = (i == gap) ? wd : DW'($urandom);
                    @(negedge clk);
                    check("wsetup_strobes", {ce[n], oe[n], we[n]}, 3'b011);
                    check("wsetup_addr", sa[n], ea);
                    check("wsetup_ready", {wr_ready[n], req_ready[n], done[n]}, 3'b100);
                    step();
                end
                wr_valid[n] = 1'b0;
                wr_data[n] = DW'($urandom);
                ref_mem[n][ea] = wd;
            end else begin
                @(negedge clk);
                check("rsetup_strobes", {ce[n], oe[n], we[n]}, 3'b011);
                check("rsetup_addr", sa[n], ea);
                check("rsetup_ready", {wr_ready[n], req_ready[n], done[n]}, 3'b000);
                check("rsetup_rd_valid", rd_valid[n], k > 0);
                if (k > 0) check("rd_data", rd_data[n], ref_mem[n][8'(ea - 1)]);
                step();
            end
            for (int j = 0; j <= w; j++) begin
                @(negedge clk);
                check("access_strobes", {ce[n], oe[n], we[n]}, r ? 3'b001 : 3'b010);
                check("access_addr", sa[n], ea);
                check("access_pulses", {rd_valid[n], done[n], req_ready[n]}, 3'b000);
                if (!r) check("access_wdata", sd_obs[n], wd);
                if (k == abort_k && j == w) begin
                    reset = 1'b1;
                    req[n] = 1'b0;
                    step();
                    reset = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        check("abort_strobes", {ce[n], oe[n], we[n]}, 3'b111);
                        check("abort_state", {req_ready[n], rd_valid[n], done[n]}, 3'b100);
                        step();
                    end
                    return;
                end
                step();
            end
        end
        @(negedge clk);
        check("done_pulse", {done[n], req_ready[n]}, 2'b10);
        check("done_strobes", {ce[n], oe[n], we[n]}, 3'b111);
        check("done_rd_valid", rd_valid[n], r);
        if (r) check("rd_data_last", rd_data[n], ref_mem[n][8'(a + l)]);
        step();
        req[n] = 1'b0;
    endtask
    initial begin
        for (int n = 0; n < 2; n++) begin
            req[n] = 1'b0; rw[n] = 1'b0; wr_valid[n] = 1'b0;
            addr[n] = '0; len[n] = '0; wr_data[n] = '0;
            for (int i = 0; i < 256; i++) ref_mem[n][i] = init_val(i);
        end
        step();
        step();
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            check("rst_req_ready", req_ready[n], 1'b1);
            check("rst_pulses", {wr_ready[n], rd_valid[n], done[n]}, 3'b000);
            check("rst_rd_data", rd_data[n], 16'h0);
            check("rst_addr", sa[n], 8'h00);
            check("rst_strobes", {ce[n], oe[n], we[n]}, 3'b111);
        end
        step();
        reset = 1'b0;
        idle(0, 2);
        run_cmd(0, 1'b0, 8'h10, 0, 0, -1, 16'hA5A5, 1'b0, -1);
        run_cmd(0, 1'b1, 8'h10, 0, 0, -1, -1, 1'b0, -1);
        check("readback_a5a5", ref_mem[0][8'h10], 16'hA5A5);
        idle(0, 1);
        run_cmd(0, 1'b1, 8'h20, 7, 0, -1, -1, 1'b0, -1);
        run_cmd(0, 1'b0, 8'hFE, 3, 1, 3, -1, 1'b0, -1);
        run_cmd(0, 1'b1, 8'hFE, 3, 0, -1, -1, 1'b0, -1);
        idle(1, 1);
        run_cmd(1, 1'b1, 8'h33, 0, 0, -1, -1, 1'b0, -1);
        idle(0, 1);
        run_cmd(0, 1'b1, 8'h40, 3, 0, -1, -1, 1'b0, 1);
        run_cmd(0, 1'b1, 8'h40, 3, 0, -1, -1, 1'b0, -1);
        run_cmd(0, 1'b1, 8'h80, 5, 0, -1, -1, 1'b1, -1);
        run_cmd(0, 1'b0, 8'h90, 2, 2, -1, -1, 1'b1, -1);
        run_cmd(1, 1'b0, 8'hFF, 1, 2, -1, -1, 1'b1, -1);
        run_cmd(1, 1'b1, 8'hFF, 1, 0, -1, -1, 1'b0, -1);
        for (int t = 0; t < 60; t++) begin
            run_cmd(int'($urandom_range(1, 0)), 1'($urandom), AW'($urandom), int'($urandom_range(7, 0)),
                    3, -1, -1, 1'($urandom), -1);
            if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(1, 0)), 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
